// File: rtl/seq_sweep_pkg.sv
// Shared types and constants for the Sequential_Circuit sweeper.
package seq_sweep_pkg;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RST   = 2'd1,
    DRIVE = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

  // Counter width able to hold (max_cycles - 1); never narrower than 1 bit.
  function automatic int cnt_width(input int max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/seq_hold_timer.sv
// Down-counter with synchronous load and a terminal-count flag.
// Loading N-1 makes tc rise after N cycles in the loaded phase.
module seq_hold_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/seq_circuit_sweeper.sv
// Autonomous sweeper for the three-input Sequential_Circuit block.
// Resets the DUT, walks {a,b,c} through 0..7 holding each vector for
// HOLD_CYCLES, samples z at the end of each hold into result[vec], then
// offers the map to the master.
//
// Result handshake: done acts as "valid". result is stable for as long as
// done is high, and the sweep completes on the first clock edge where done
// and ack are both high. abort also drops done.
module seq_circuit_sweeper
  import seq_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int RST_CYCLES  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               ack,
  input  logic               z_in,
  output logic               a_out,
  output logic               b_out,
  output logic               c_out,
  output logic               dut_reset,
  output logic               busy,
  output logic               done,
  output logic [NUM_VEC-1:0] result,
  output logic [VEC_W-1:0]   vec_idx,
  output sweep_state_e       state_dbg
);

  localparam int MAX_CYC = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
  localparam int CNT_W   = cnt_width(MAX_CYC);
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(NUM_VEC - 1);

  sweep_state_e       state, state_n;
  logic [VEC_W-1:0]   vec_n;
  logic [VEC_W-1:0]   drive_n;
  logic [NUM_VEC-1:0] result_n;
  logic               busy_n, done_n, dut_reset_n;

  logic               tmr_load, tmr_en, tmr_tc;
  logic [CNT_W-1:0]   tmr_val;

  assign state_dbg = state;

  // One timer serves both the reset window and each vector hold.
  seq_hold_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; abort always wins over start, sample or completion.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start && !abort) state_n = RST;
      RST: begin
        if (abort)       state_n = IDLE;
        else if (tmr_tc) state_n = DRIVE;
      end
      DRIVE: begin
        if (abort)                             state_n = IDLE;
        else if (tmr_tc && vec_idx == LAST_VEC) state_n = DONE;
      end
      DONE:  if (ack || abort) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Timer control: RST window loaded on start, hold reloaded on each boundary.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = HOLD_LOAD;
    tmr_en   = (state == RST) || (state == DRIVE);
    if (state == IDLE && start && !abort) begin
      tmr_load = 1'b1;
      tmr_val  = RST_LOAD;
    end else if ((state == RST || state == DRIVE) && tmr_tc && !abort) begin
      tmr_load = 1'b1;
      tmr_val  = HOLD_LOAD;
    end
  end

  // Output logic: next values for every registered output.
  always_comb begin
    vec_n    = vec_idx;
    result_n = result;
    unique case (state)
      IDLE: begin
        vec_n = '0;
        if (start && !abort) result_n = '0;
      end
      RST: begin
        if (abort) begin
          vec_n    = '0;
          result_n = '0;
        end
      end
      DRIVE: begin
        if (abort) begin
          vec_n    = '0;
          result_n = '0;
        end else if (tmr_tc) begin
          result_n[vec_idx] = z_in;
          if (vec_idx != LAST_VEC) vec_n = vec_idx + VEC_W'(1);
        end
      end
      DONE: begin
        if (ack || abort) vec_n = '0;
      end
      default: vec_n = '0;
    endcase
    drive_n     = (state_n == DRIVE || state_n == DONE) ? vec_n : '0;
    dut_reset_n = (state_n == IDLE) || (state_n == RST);
    busy_n      = (state_n == RST) || (state_n == DRIVE);
    done_n      = (state_n == DONE);
  end

  // Output registers; reset holds the DUT in reset as well.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      c_out     <= 1'b0;
      dut_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      vec_idx   <= '0;
    end else begin
      a_out     <= drive_n[2];
      b_out     <= drive_n[1];
      c_out     <= drive_n[0];
      dut_reset <= dut_reset_n;
      busy      <= busy_n;
      done      <= done_n;
      result    <= result_n;
      vec_idx   <= vec_n;
    end
  end

endmodule

// File: tb/tb_seq_circuit_sweeper.sv
// Bench for seq_circuit_sweeper: instance 0 uses default parameters with a
// registered-z DUT model, instance 1 uses HOLD_CYCLES=1 with a
// combinational-z model. Expected traces come from the sweep timing rules.
module tb_seq_circuit_sweeper;
  import seq_sweep_pkg::*;

  localparam int RST_C = 1;
  localparam int H0    = 2;
  localparam int H1    = 1;

  int checks   = 0;
  int failures = 0;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]   start_v, abort_v, ack_v;
  logic [1:0]   a_v, b_v, c_v, dr_v, busy_v, done_v;
  logic [7:0]   res_v [2];
  logic [2:0]   vi_v  [2];
  sweep_state_e st_v  [2];
  logic [7:0]   tt_v  [2];
  logic         z0, z1;
  logic [2:0]   vec0, vec1;

  assign vec0 = {a_v[0], b_v[0], c_v[0]};
  assign vec1 = {a_v[1], b_v[1], c_v[1]};

  // DUT models: registered z (instance 0) and combinational z (instance 1).
  always_ff @(posedge clk) z0 <= dr_v[0] ? 1'b0 : tt_v[0][vec0];
  assign z1 = tt_v[1][vec1];

  seq_circuit_sweeper #(.HOLD_CYCLES(H0), .RST_CYCLES(RST_C)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
    .ack(ack_v[0]), .z_in(z0), .a_out(a_v[0]), .b_out(b_v[0]),
    .c_out(c_v[0]), .dut_reset(dr_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .result(res_v[0]), .vec_idx(vi_v[0]),
    .state_dbg(st_v[0])
  );

  seq_circuit_sweeper #(.HOLD_CYCLES(H1), .RST_CYCLES(RST_C)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
    .ack(ack_v[1]), .z_in(z1), .a_out(a_v[1]), .b_out(b_v[1]),
    .c_out(c_v[1]), .dut_reset(dr_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .result(res_v[1]), .vec_idx(vi_v[1]),
    .state_dbg(st_v[1])
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int hold_of(input int k);
    return (k == 0) ? H0 : H1;
  endfunction

  function automatic logic [7:0] tt_and_ab();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = ((i >> 2) & 1) & ((i >> 1) & 1);
    return t;
  endfunction

  function automatic logic [7:0] tt_parity();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = ((i >> 2) ^ (i >> 1) ^ i) & 1;
    return t;
  endfunction

  task automatic check_idle(input int k, input logic [7:0] exp_res, input string tag);
    check({tag, "_busy"},  32'(busy_v[k]), 32'd0);
    check({tag, "_done"},  32'(done_v[k]), 32'd0);
    check({tag, "_dutrst"}, 32'(dr_v[k]), 32'd1);
    check({tag, "_result"}, 32'(res_v[k]), 32'(exp_res));
    check({tag, "_vec"},   32'({a_v[k], b_v[k], c_v[k]}), 32'd0);
    check({tag, "_state"}, 32'(st_v[k]), 32'(IDLE));
  endtask

  // Driver + model: one sweep on instance k. abort_t < 0 means no abort.
  task automatic run_sweep(input int k, input logic [7:0] tt, input int abort_t, input bit stray);
    int h;
    int len;
    int n;
    logic [7:0] mask;
    h   = hold_of(k);
    len = RST_C + 8 * h;
    tt_v[k] = tt;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    for (int t = 0; t < len; t++) begin
      n    = (t < RST_C) ? 0 : (t - RST_C) / h;
      mask = 8'((1 << n) - 1);
      check("sw_busy",   32'(busy_v[k]), 32'd1);
      check("sw_done",   32'(done_v[k]), 32'd0);
      check("sw_dutrst", 32'(dr_v[k]), (t < RST_C) ? 32'd1 : 32'd0);
      check("sw_vecidx", 32'(vi_v[k]), 32'(n));
      check("sw_abc",    32'({a_v[k], b_v[k], c_v[k]}), 32'(n));
      check("sw_result", 32'(res_v[k]), 32'(tt & mask));
      if (t == abort_t) begin
        abort_v[k] = 1'b1;
        tick();
        abort_v[k] = 1'b0;
        check_idle(k, 8'h00, "abort");
        for (int j = 0; j < 3; j++) begin
          tick();
          check_idle(k, 8'h00, "post_abort");
        end
        return;
      end
      if (stray && t == len / 2) start_v[k] = 1'b1;
      tick();
      start_v[k] = 1'b0;
    end
    check("dn_done",   32'(done_v[k]), 32'd1);
    check("dn_busy",   32'(busy_v[k]), 32'd0);
    check("dn_result", 32'(res_v[k]), 32'(tt));
    check("dn_vecidx", 32'(vi_v[k]), 32'd7);
    check("dn_abc",    32'({a_v[k], b_v[k], c_v[k]}), 32'd7);
    if (stray) begin
      start_v[k] = 1'b1;
      tick();
      start_v[k] = 1'b0;
      check("dn_stray_done",   32'(done_v[k]), 32'd1);
      check("dn_stray_busy",   32'(busy_v[k]), 32'd0);
      check("dn_stray_result", 32'(res_v[k]), 32'(tt));
    end
    repeat ($urandom_range(0, 2)) begin
      tick();
      check("dn_hold_done",   32'(done_v[k]), 32'd1);
      check("dn_hold_result", 32'(res_v[k]), 32'(tt));
    end
    ack_v[k] = 1'b1;
    tick();
    ack_v[k] = 1'b0;
    check_idle(k, tt, "ack");
  endtask

  // Bounded run time.
  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int k;
    int ab;
    logic [7:0] tt;
    reset   = 1'b1;
    start_v = '0;
    abort_v = '0;
    ack_v   = '0;
    tt_v[0] = '0;
    tt_v[1] = '0;
    #1;
    for (int i = 0; i < 2; i++) check_idle(i, 8'h00, "por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) check_idle(i, 8'h00, "rel");

    // Registered a&b, default parameters, with stray starts in DRIVE and DONE.
    run_sweep(0, tt_and_ab(), -1, 1'b1);
    // Rerun: result must clear on start and rebuild.
    run_sweep(0, tt_and_ab(), -1, 1'b0);
    // Combinational parity, HOLD_CYCLES = 1.
    run_sweep(1, tt_parity(), -1, 1'b0);
    // Abort while vec_idx = 3.
    run_sweep(0, 8'hFF, RST_C + 3 * H0, 1'b0);
    run_sweep(1, 8'hFF, RST_C + 3 * H1, 1'b0);

    // start and abort together in IDLE.
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    check_idle(0, 8'h00, "start_abort");
    tick();
    check_idle(0, 8'h00, "start_abort2");

    // Asynchronous reset in the middle of DRIVE, between clock edges.
    tt_v[0] = 8'hA5;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (6) tick();
    check("mid_busy", 32'(busy_v[0]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle(0, 8'h00, "async_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check_idle(0, 8'h00, "after_rst");
    end

    // Randomized sweeps with random truth tables and abort points.
    for (int i = 0; i < 12; i++) begin
      k  = $urandom_range(0, 1);
      tt = 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, RST_C + 8 * hold_of(k) - 1) : -1;
      run_sweep(k, tt, ab, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
